// File: rtl/resp_line_parser.sv
// resp_line_parser: collects one "RESP:<32 hex digits>\n" line from a UART
// byte stream after an arm strobe and reports the 128-bit value or an error.
// Optional feature: define RESP_PARSER_LOWERCASE_EN to accept 'a'-'f' as hex.
module resp_line_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 60_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         arm,
  output logic [127:0] resp_value,
  output logic         resp_valid,
  output logic         resp_error,
  output logic [2:0]   err_code,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, HDR, HEX, EOL, SYNC} state_t;

  localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LF        = 8'h0A;

  state_t      state;
  logic [2:0]  hdr_idx;
  logic [4:0]  nib_cnt;
  logic [25:0] idle_cnt;
  logic [4:0]  hex_dec;

  // Expected header character at a given index of "RESP:"
  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h52;
      3'd1:    return 8'h45;
      3'd2:    return 8'h53;
      3'd3:    return 8'h50;
      default: return 8'h3A;
    endcase
  endfunction

  // Hex decode: bit 4 flags a valid digit, bits 3:0 carry the nibble
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, 4'(b - 8'h30)};
    if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
`ifdef RESP_PARSER_LOWERCASE_EN
    if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
`else
`endif
    return 5'd0;
  endfunction

  assign hex_dec = hex_decode(rx_data);

  // Line collection FSM with registered pulses, error code and idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hdr_idx    <= '0;
      nib_cnt    <= '0;
      idle_cnt   <= '0;
      resp_value <= '0;
      err_code   <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      if (arm) begin
        // arm wins over a same-cycle byte and restarts an active line
        state      <= HDR;
        hdr_idx    <= '0;
        nib_cnt    <= '0;
        idle_cnt   <= '0;
        resp_value <= '0;
        err_code   <= '0;
        busy       <= 1'b1;
      end else if (state != IDLE) begin
        if (rx_valid) begin
          // a byte arriving on the timeout cycle is processed, timeout dropped
          idle_cnt <= '0;
          case (state)
            HDR: begin
              if (rx_data == hdr_char(hdr_idx)) begin
                if (hdr_idx == 3'd4) state <= HEX;
                else hdr_idx <= hdr_idx + 3'd1;
              end else begin
                resp_error <= 1'b1;
                err_code   <= 3'd1;
                hdr_idx    <= '0;
                nib_cnt    <= '0;
                state      <= (rx_data == LF) ? HDR : SYNC;
              end
            end
            HEX: begin
              if (hex_dec[4]) begin
                resp_value <= {resp_value[123:0], hex_dec[3:0]};
                nib_cnt    <= nib_cnt + 5'd1;
                if (nib_cnt == 5'd31) state <= EOL;
              end else begin
                resp_error <= 1'b1;
                err_code   <= 3'd2;
                hdr_idx    <= '0;
                nib_cnt    <= '0;
                state      <= (rx_data == LF) ? HDR : SYNC;
              end
            end
            EOL: begin
              if (rx_data == LF) begin
                resp_valid <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                resp_error <= 1'b1;
                err_code   <= 3'd3;
                state      <= SYNC;
              end
            end
            SYNC: begin
              if (rx_data == LF) begin
                state   <= HDR;
                hdr_idx <= '0;
                nib_cnt <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end else if (idle_cnt == IDLE_LAST) begin
          resp_error <= 1'b1;
          err_code   <= 3'd4;
          state      <= IDLE;
          busy       <= 1'b0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 26'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_resp_line_parser.sv
// tb_resp_line_parser: directed stimulus with a scoreboard queue; a monitor
// pops expected events whenever resp_valid or resp_error pulses.
module tb_resp_line_parser;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         arm = 1'b0;
  logic [127:0] resp_value;
  logic         resp_valid;
  logic         resp_error;
  logic [2:0]   err_code;
  logic         busy;

  typedef struct {
    bit           is_err;
    logic [2:0]   code;
    logic [127:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  resp_line_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .arm(arm),
    .resp_value(resp_value), .resp_valid(resp_valid), .resp_error(resp_error),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_valid(input logic [127:0] v);
    exp_t e;
    e.is_err = 1'b0; e.code = '0; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] c);
    exp_t e;
    e.is_err = 1'b1; e.code = c; e.val = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every output pulse against the scoreboard head
  always @(negedge clk) begin
    if (!rst && (resp_valid || resp_error)) begin
      exp_t e;
      if (resp_valid && resp_error) begin
        check("pulse_exclusive", 1, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {resp_valid, resp_error}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", resp_error, e.is_err);
        if (e.is_err) check("err_code", err_code, e.code);
        else          check("resp_value", resp_value, e.val);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  string hx_a = "0123456789ABCDEF0123456789ABCDEF";
  string hx_f = "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF";
  string hx_r = "FEDCBA9876543210FEDCBA9876543210";
  string lc_a = "aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa";

  initial begin
    int waited;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_value", resp_value, 0);
    check("rst_err_code", err_code, 0);
    check("rst_pulses", {resp_valid, resp_error}, 2'b00);
    rst = 1'b0;
    idle(2);

    // Bytes in IDLE are ignored
    send_str("RESP:");
    send_byte(8'h0A);
    check("idle_busy", busy, 0);

    // Basic valid line
    do_arm();
    check("arm_busy", busy, 1);
    check("arm_clears_value", resp_value, 0);
    send_str("RESP:");
    send_str(hx_a);
    push_valid(128'h0123456789ABCDEF0123456789ABCDEF);
    send_byte(8'h0A);
    idle(3);
    check("done_busy", busy, 0);
    check("value_stable", resp_value, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Header mismatch, resync, then a valid line without re-arm
    do_arm();
    send_str("RES");
    push_err(3'd1);
    send_byte("X");
    send_str("Y:12Z");
    check("sync_busy", busy, 1);
    send_byte(8'h0A);
    send_str("RESP:");
    send_str(hx_r);
    push_valid(128'hFEDCBA9876543210FEDCBA9876543210);
    send_byte(8'h0A);
    idle(2);

    // Non-hex digit, then arm and an all-F line
    do_arm();
    send_str("RESP:0123456789");
    push_err(3'd2);
    send_byte("G");
    idle(2);
    check("err_code_held", err_code, 3'd2);
    do_arm();
    check("arm_clears_err", err_code, 0);
    send_str("RESP:");
    send_str(hx_f);
    push_valid('1);
    send_byte(8'h0A);
    idle(2);

    // Bad terminator -> SYNC; LF returns to HDR still armed
    do_arm();
    send_str("RESP:");
    send_str(hx_a);
    push_err(3'd3);
    send_byte(8'h0D);
    check("eol_err_busy", busy, 1);
    send_byte(8'h0A);
    check("resync_busy", busy, 1);
    send_str("RESP:");
    send_str(hx_r);
    push_valid(128'hFEDCBA9876543210FEDCBA9876543210);
    send_byte(8'h0A);
    idle(2);

    // Arm together with a byte: byte dropped, line restarts
    do_arm();
    send_str("RESP:01");
    rx_data = "2"; rx_valid = 1'b1; arm = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; arm = 1'b0;
    check("rearm_clears_value", resp_value, 0);
    send_str("RESP:");
    send_str(hx_a);
    push_valid(128'h0123456789ABCDEF0123456789ABCDEF);
    send_byte(8'h0A);
    idle(2);

    // Timeout: error exactly 100 cycles after the 'E' strobe
    do_arm();
    send_byte("R");
    push_err(3'd4);
    send_byte("E");
    waited = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (resp_error) begin waited = k; break; end
    end
    check("timeout_latency", waited, 100);
    idle(1);
    check("timeout_busy", busy, 0);

    // Lowercase hex digits
    do_arm();
    send_str("RESP:");
`ifdef RESP_PARSER_LOWERCASE_EN
    send_str(lc_a);
    push_valid({32{4'hA}});
    send_byte(8'h0A);
    idle(2);
    check("lower_busy", busy, 0);
`else
    push_err(3'd2);
    send_str(lc_a);
    send_byte(8'h0A);
    idle(2);
    check("lower_err_code", err_code, 3'd2);
    check("lower_busy", busy, 1);
`endif

    // Reset mid-line abandons it; following bytes ignored without arm
    do_arm();
    send_str("RESP:01");
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_value", resp_value, 0);
    send_str("RESP:");
    send_str(hx_a);
    send_byte(8'h0A);
    idle(4);
    check("midrst_after_busy", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/resp_line_parser.md
RESP_LINE_PARSER -- requirements
Module: resp_line_parser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 60_000_000, meaning the maximum idle cycles between bytes while receiving (5 s at 12 MHz).
REQ-002 The block SHALL have port clk, input, 1, system clock; one clock only; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port rx_data, input, 8, received byte from uart_rx.
REQ-005 The block SHALL have port rx_valid, input, 1, single-cycle strobe qualifying rx_data.
REQ-006 The block SHALL have port arm, input, 1, single-cycle strobe that starts collection of a new response line.
REQ-007 The block SHALL have port resp_value, output, 128, parsed response value, first hex digit most significant.
REQ-008 The block SHALL have port resp_valid, output, 1, one-cycle pulse when resp_value holds a complete, well-formed response.
REQ-009 The block SHALL have port resp_error, output, 1, one-cycle pulse on a malformed line or timeout.
REQ-010 The block SHALL have port err_code, output, 3, cause of the last error: 1 header, 2 hex digit, 3 terminator, 4 timeout; held until the next arm.
REQ-011 The block SHALL have port busy, output, 1, high while armed (any state other than IDLE).

Function
REQ-012 The block SHALL implement states IDLE, HDR, HEX, EOL and SYNC.
REQ-013 In IDLE, bytes SHALL be ignored; arm SHALL move the FSM to HDR with header index 0, nibble count 0 and resp_value cleared.
REQ-014 In HDR, each byte SHALL be compared with "RESP:" (0x52 0x45 0x53 0x50 0x3A) at the header index; a match advances the index, and after ':' the FSM enters HEX.
REQ-015 A header mismatch SHALL pulse resp_error with err_code=1, then enter SYNC; if the mismatching byte is 0x0A, the FSM SHALL instead return to HDR at index 0.
REQ-016 In HEX, each byte '0'-'9' or 'A'-'F' SHALL shift its nibble into the LSBs of resp_value (resp_value <= {resp_value[123:0], nibble}); after the 32nd nibble the FSM enters EOL.
REQ-017 A non-hex byte in HEX SHALL give err_code=2 with the same SYNC/0x0A rule as REQ-015.
REQ-018 In EOL, byte 0x0A SHALL pulse resp_valid on the next cycle and return to IDLE; any other byte SHALL give err_code=3 and enter SYNC.
REQ-019 In SYNC, bytes SHALL be discarded until 0x0A, after which the FSM SHALL return to HDR at index 0 (still armed, no pulse).
REQ-020 Latency: resp_valid and resp_error SHALL each assert exactly one cycle after the rx_valid cycle that caused them, and never in the same cycle.
REQ-021 resp_value SHALL be stable from the resp_valid pulse until the next arm.
REQ-022 A 26-bit idle counter SHALL clear on every rx_valid and on arm, and increment every cycle in HDR/HEX/EOL/SYNC.
REQ-023 When the idle counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse resp_error with err_code=4 and return to IDLE (disarmed).
REQ-024 If arm and rx_valid occur in the same cycle, arm SHALL win and the byte SHALL be discarded; arm while busy SHALL restart collection at HDR.
REQ-025 A timeout and rx_valid in the same cycle SHALL process the byte, with no timeout.

Reset
REQ-026 While rst is high, the block SHALL set state to IDLE; resp_value, err_code, the counters and indices to 0; and resp_valid, resp_error and busy low.
REQ-027 rst mid-line SHALL abandon the line with no pulse; the first byte after release SHALL be ignored unless arm is given.

Configuration
REQ-028 With RESP_PARSER_LOWERCASE_EN defined, 'a'-'f' (0x61-0x66) SHALL be accepted as hex digits 10-15; without it, they SHALL be treated as non-hex (err_code=2).

Verification
REQ-029 The bench SHALL cover: arm, then "RESP:" + "0123456789ABCDEF0123456789ABCDEF" + 0x0A -> one resp_valid pulse with resp_value=128'h0123456789ABCDEF0123456789ABCDEF, busy low afterwards.
REQ-030 The bench SHALL cover: arm, then "RESX" -> resp_error with err_code=1 on the 'X' byte+1; the remaining bytes up to 0x0A are discarded; a following valid line -> resp_valid.
REQ-031 The bench SHALL cover: arm, "RESP:" plus 10 hex digits, then 'G' -> err_code=2; then arm and a valid line of all 'F' -> resp_value all ones.
REQ-032 The bench SHALL cover: a valid 32-digit line ending 0x0D instead of 0x0A -> err_code=3, FSM in SYNC; then 0x0A -> FSM in HDR, busy high.
REQ-033 The bench SHALL cover: TIMEOUT_CYCLES=100, arm, "RE", then silence -> resp_error with err_code=4 exactly 100 cycles after the 'E' strobe, busy low.
REQ-034 The bench SHALL cover: lowercase "RESP:" + 32x'a' + 0x0A -> resp_valid with value 128'hAAAA...A when RESP_PARSER_LOWERCASE_EN is defined, and err_code=2 on the first 'a' when it is not.
